// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for pipe_reg_chain: upstream and downstream valid/ready/data.
// The master side drives the upstream beat and downstream ready. The slave side is the chain itself.
interface pipe_reg_chain_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Parametrised delay chain. Every REG_INTERVAL-th level is a valid/ready register stage, and empty stages collapse.
// Supports synchronous flush, global enable gating, and an occupancy count of the valid stages.
module pipe_reg_chain #(
  parameter int                DATA_W       = 8,
  parameter int                LEVELS       = 8,
  parameter int                REG_INTERVAL = 2,
  parameter logic [DATA_W-1:0] RESET_DATA   = '0,
  localparam int NREG  = (REG_INTERVAL == 0) ? 0 : (LEVELS + REG_INTERVAL - 1) / REG_INTERVAL,
  localparam int OCC_W = (NREG == 0) ? 1 : $clog2(NREG + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  pipe_reg_chain_if.slave  bus,
  output logic [OCC_W-1:0] occ
);

  logic gate;
  assign gate = en & ~flush;

  if (NREG == 0) begin : g_wire
    assign bus.out_data  = bus.in_data;
    assign bus.out_valid = bus.in_valid & gate;
    assign bus.in_ready  = bus.out_ready & gate;
    assign occ           = '0;
  end else begin : g_reg
    logic [NREG-1:0]   v;
    logic [DATA_W-1:0] d  [NREG];
    logic [NREG-1:0]   vp;
    logic [DATA_W-1:0] dp [NREG];
    logic [NREG-1:0]   r;
    logic              all_full;

    // r[s] = ~v[s] | r[s+1] unrolled: a stage may load when any stage at or downstream of it
    // is empty, or when the sink takes a beat.
    always_comb begin
      all_full = 1'b1;
      r        = '0;
      for (int s = NREG - 1; s >= 0; s--) begin
        all_full = all_full & v[s];
        r[s]     = bus.out_ready | ~all_full;
      end
    end

    always_comb begin
      vp[0] = bus.in_valid;
      dp[0] = bus.in_data;
      for (int s = 1; s < NREG; s++) begin
        vp[s] = v[s-1];
        dp[s] = d[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= '0;
        for (int s = 0; s < NREG; s++) d[s] <= RESET_DATA;
      end else if (flush) begin
        v <= '0;
      end else if (en) begin
        for (int s = 0; s < NREG; s++) begin
          if (r[s]) begin
            v[s] <= vp[s];
            if (vp[s]) d[s] <= dp[s];
          end
        end
      end
    end

    always_comb begin
      occ = '0;
      for (int s = 0; s < NREG; s++) occ = occ + OCC_W'(v[s]);
    end

    assign bus.in_ready  = r[0] & gate;
    assign bus.out_valid = v[NREG-1] & gate;
    assign bus.out_data  = d[NREG-1];
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: four parameter sets share one stimulus stream and are each checked against a
// beat-list model. A directed vector table and hand sequences cover the NREG=4 instance.
module tb_pipe_reg_chain;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_reg_chain_if #(.DATA_W(8)) ifa ();
  pipe_reg_chain_if #(.DATA_W(8)) ifb ();
  pipe_reg_chain_if #(.DATA_W(8)) ifc ();
  pipe_reg_chain_if #(.DATA_W(8)) ifd ();

  logic [2:0] occ_a;
  logic [0:0] occ_b;
  logic [1:0] occ_c;
  logic [0:0] occ_d;

  assign ifa.in_valid = in_valid;  assign ifa.in_data = in_data;  assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;  assign ifb.in_data = in_data;  assign ifb.out_ready = out_ready;
  assign ifc.in_valid = in_valid;  assign ifc.in_data = in_data;  assign ifc.out_ready = out_ready;
  assign ifd.in_valid = in_valid;  assign ifd.in_data = in_data;  assign ifd.out_ready = out_ready;

  pipe_reg_chain #(.DATA_W(8), .LEVELS(8), .REG_INTERVAL(2), .RESET_DATA(8'hC3)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .bus(ifa), .occ(occ_a));
  pipe_reg_chain #(.DATA_W(8), .LEVELS(8), .REG_INTERVAL(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .bus(ifb), .occ(occ_b));
  pipe_reg_chain #(.DATA_W(8), .LEVELS(8), .REG_INTERVAL(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .bus(ifc), .occ(occ_c));
  pipe_reg_chain #(.DATA_W(8), .LEVELS(1), .REG_INTERVAL(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .bus(ifd), .occ(occ_d));

  // Model: per instance, the in-flight beats front-first with their stage position.
  int         nreg_of [4];
  int         cnt     [4];
  int         mpos    [4][4];
  logic [7:0] mdat    [4][4];

  logic       s_ov  [4];
  logic       s_ir  [4];
  logic [7:0] s_od  [4];
  int         s_occ [4];

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       en;
    logic       fl;
    logic       eir;
    logic       eov;
    logic [7:0] eod;
    logic       chk_od;
    int         eocc;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic iv, logic [7:0] id, logic ordy, logic e, logic fl,
                              logic eir, logic eov, logic [7:0] eod, logic chk_od, int eocc);
    vec_t t;
    t.iv = iv; t.id = id; t.ordy = ordy; t.en = e; t.fl = fl;
    t.eir = eir; t.eov = eov; t.eod = eod; t.chk_od = chk_od; t.eocc = eocc;
    tbl.push_back(t);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void sample();
    s_ov[0] = ifa.out_valid; s_ir[0] = ifa.in_ready; s_od[0] = ifa.out_data; s_occ[0] = int'(occ_a);
    s_ov[1] = ifb.out_valid; s_ir[1] = ifb.in_ready; s_od[1] = ifb.out_data; s_occ[1] = int'(occ_b);
    s_ov[2] = ifc.out_valid; s_ir[2] = ifc.in_ready; s_od[2] = ifc.out_data; s_occ[2] = int'(occ_c);
    s_ov[3] = ifd.out_valid; s_ir[3] = ifd.in_ready; s_od[3] = ifd.out_data; s_occ[3] = int'(occ_d);
  endfunction

  // A beat moves one stage if the sink is taking beats or a free slot lies ahead of it.
  function automatic void model_update(int k);
    int         nr;
    int         n;
    int         p;
    int         npos [4];
    logic [7:0] ndat [4];
    bit         fire_in;
    nr = nreg_of[k];
    if (flush) begin
      cnt[k] = 0;
      return;
    end
    if (!en || nr == 0) return;
    fire_in = in_valid && (cnt[k] < nr || out_ready);
    n = 0;
    for (int i = 0; i < cnt[k]; i++) begin
      p = mpos[k][i];
      if (out_ready || i < nr - 1 - p) p++;
      if (p < nr) begin
        npos[n] = p;
        ndat[n] = mdat[k][i];
        n++;
      end
    end
    if (fire_in) begin
      npos[n] = 0;
      ndat[n] = in_data;
      n++;
    end
    for (int i = 0; i < n; i++) begin
      mpos[k][i] = npos[i];
      mdat[k][i] = ndat[i];
    end
    cnt[k] = n;
  endfunction

  task automatic model_check();
    logic g, eov, eir;
    logic [7:0] eod;
    int eocc;
    g = en & ~flush;
    for (int k = 0; k < 4; k++) begin
      if (nreg_of[k] == 0) begin
        eov = in_valid & g; eir = out_ready & g; eod = in_data; eocc = 0;
      end else begin
        eov  = (cnt[k] > 0 && mpos[k][0] == nreg_of[k] - 1) & g;
        eir  = (cnt[k] < nreg_of[k] || out_ready) & g;
        eod  = mdat[k][0];
        eocc = cnt[k];
      end
      chk($sformatf("m%0d_out_valid", k), int'(s_ov[k]), int'(eov));
      chk($sformatf("m%0d_in_ready", k), int'(s_ir[k]), int'(eir));
      chk($sformatf("m%0d_occ", k), s_occ[k], eocc);
      if (eov) chk($sformatf("m%0d_out_data", k), int'(s_od[k]), int'(eod));
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    model_check();
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_update(k);
    #1;
  endtask

  int lat  [4];
  bit seen [4];

  initial begin
    nreg_of = '{4, 0, 3, 1};
    cnt     = '{0, 0, 0, 0};
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Reset values
    #12;
    sample();
    chk("rst_out_valid", int'(s_ov[0]), 0);
    chk("rst_occ", s_occ[0], 0);
    chk("rst_out_data", int'(s_od[0]), 8'hC3);
    chk("rst_in_ready", int'(s_ir[0]), 1);
    chk("rst_occ_c", s_occ[2], 0);
    chk("rst_out_valid_d", int'(s_ov[3]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back stream 0x01..0x10 with the sink always ready
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 16);
      in_data  = 8'(i + 1);
      step();
      if (i < 16) chk("stream_in_ready", int'(s_ir[0]), 1);
      if (i >= 4) begin
        chk("stream_out_valid", int'(s_ov[0]), 1);
        chk("stream_out_data", int'(s_od[0]), i - 3);
      end else begin
        chk("stream_out_valid_fill", int'(s_ov[0]), 0);
      end
      if (i >= 4 && i <= 16) chk("stream_occ", s_occ[0], 4);
    end

    // Stall, bubble collapse, flush and enable-gating vectors
    add(1, 8'hA0, 0, 1, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'hA1, 0, 1, 0, 1, 0, 8'h00, 0, 1);
    add(1, 8'hA2, 0, 1, 0, 1, 0, 8'h00, 0, 2);
    add(1, 8'hA3, 0, 1, 0, 1, 0, 8'h00, 0, 3);
    add(1, 8'hA4, 0, 1, 0, 0, 1, 8'hA0, 0, 4);
    add(1, 8'hA5, 0, 1, 0, 0, 1, 8'hA0, 0, 4);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'hA0, 0, 4);
    add(1, 8'hA4, 1, 1, 0, 1, 1, 8'hA1, 0, 3);
    add(1, 8'hA5, 1, 1, 0, 1, 1, 8'hA2, 0, 3);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'hA3, 0, 3);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0, 2);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'hA4, 0, 2);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'hA5, 0, 1);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0, 0);

    add(1, 8'h11, 0, 1, 0, 1, 0, 8'h00, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0, 1);
    add(1, 8'h22, 0, 1, 0, 1, 0, 8'h00, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 1, 8'h11, 0, 2);
    add(0, 8'h00, 0, 1, 0, 1, 1, 8'h11, 0, 2);
    add(0, 8'h00, 0, 1, 0, 1, 1, 8'h11, 0, 2);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h11, 0, 2);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h22, 0, 1);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0, 0);

    add(1, 8'h31, 0, 1, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h32, 0, 1, 0, 1, 0, 8'h00, 0, 1);
    add(1, 8'h33, 0, 1, 0, 1, 0, 8'h00, 0, 2);
    add(1, 8'h55, 1, 1, 1, 0, 0, 8'h00, 0, 3);
    add(1, 8'h61, 1, 1, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h62, 1, 1, 0, 1, 0, 8'h00, 0, 1);
    add(1, 8'h63, 1, 1, 0, 1, 0, 8'h00, 0, 2);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0, 3);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h61, 0, 3);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h62, 0, 2);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h63, 0, 1);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0, 0);

    add(1, 8'h71, 1, 1, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h72, 1, 1, 0, 1, 0, 8'h00, 0, 1);
    add(1, 8'h73, 1, 1, 0, 1, 0, 8'h00, 0, 2);
    add(1, 8'h74, 1, 1, 0, 1, 0, 8'h00, 0, 3);
    add(1, 8'h75, 1, 1, 0, 1, 1, 8'h71, 0, 4);
    add(1, 8'h76, 1, 0, 0, 0, 0, 8'h72, 1, 4);
    add(1, 8'h76, 1, 0, 0, 0, 0, 8'h72, 1, 4);
    add(1, 8'h76, 1, 0, 0, 0, 0, 8'h72, 1, 4);
    add(1, 8'h76, 1, 1, 0, 1, 1, 8'h72, 0, 4);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h73, 0, 4);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h74, 0, 3);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h75, 0, 2);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h76, 0, 1);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
      en = tbl[i].en; flush = tbl[i].fl;
      step();
      chk($sformatf("vec%0d_in_ready", i), int'(s_ir[0]), int'(tbl[i].eir));
      chk($sformatf("vec%0d_out_valid", i), int'(s_ov[0]), int'(tbl[i].eov));
      chk($sformatf("vec%0d_occ", i), s_occ[0], tbl[i].eocc);
      if (tbl[i].eov || tbl[i].chk_od)
        chk($sformatf("vec%0d_out_data", i), int'(s_od[0]), int'(tbl[i].eod));
    end
    en = 1'b1; flush = 1'b0;

    // Reset pulsed mid-cycle while the chain is full and presenting a beat
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h81 + i);
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    sample();
    chk("midrst_out_valid", int'(s_ov[0]), 0);
    chk("midrst_occ", s_occ[0], 0);
    chk("midrst_out_data", int'(s_od[0]), 8'hC3);
    chk("midrst_occ_c", s_occ[2], 0);
    cnt = '{0, 0, 0, 0};
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("postrst_out_valid", int'(s_ov[0]), 0);
    end

    // Latency of each parameter set for a single beat into an empty chain
    lat  = '{-1, -1, -1, -1};
    seen = '{0, 0, 0, 0};
    in_data = 8'h9E;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 0);
      step();
      for (int k = 0; k < 4; k++) begin
        if (!seen[k] && s_ov[k]) begin
          seen[k] = 1'b1;
          lat[k]  = c;
          chk($sformatf("lat%0d_data", k), int'(s_od[k]), 8'h9E);
        end
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("lat%0d_cycles", k), lat[k], nreg_of[k]);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      en        = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised pipeline delay chain of LEVELS logical levels. Every REG_INTERVAL-th level is a register stage; all other levels are wires.
- Successor to the per-level reg-or-wire primitive. Adds a valid/ready handshake per registered stage with bubble collapsing, synchronous flush, clock-enable gating, asynchronous reset and an occupancy count.
- Sits between fixed-point arithmetic levels (SIFT datapath) so that retiming depth is a parameter, not a rewrite.

Parameters:
- DATA_W, 8, payload width in bits.
- LEVELS, 8, number of logical levels (>=1).
- REG_INTERVAL, 2, level idx (0..LEVELS-1) is registered iff REG_INTERVAL!=0 and idx%REG_INTERVAL==0; 0 means all wires.
- RESET_DATA, 0, value loaded into every data register on reset.
- Derived NREG = (REG_INTERVAL==0) ? 0 : ceil(LEVELS/REG_INTERVAL). OCC_W = clog2(NREG+1), minimum 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, global advance enable.
- flush, input, 1, synchronous clear of all in-flight beats.
- in_valid, input, 1, upstream beat valid.
- in_ready, output, 1, chain accepts the upstream beat.
- in_data, input, DATA_W, upstream payload.
- out_valid, output, 1, downstream beat valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, DATA_W, downstream payload.
- occ, output, OCC_W, number of valid registered stages.

Behaviour:
- Reset (rst_n=0, async): all stage valid bits=0, all data regs=RESET_DATA. Hence out_valid=0, occ=0, out_data=RESET_DATA, in_ready=en&out... (combinational, see below). Reset mid-stream drops all beats; no partial beat emerges after release.
- Stages s=0..NREG-1, where s=0 is nearest the input. Each stage has v[s] and d[s].
- Ready chain (combinational):
  - r[NREG] = out_ready.
  - r[s] = ~v[s] | r[s+1].
  - An empty stage accepts even while downstream is stalled (bubble collapse).
- Gating:
  - in_ready = r[0] & en & ~flush.
  - out_valid = v[NREG-1] & en & ~flush.
  - out_data = d[NREG-1].
- Stage update each posedge, when en=1 and flush=0:
  - If r[s]=1, then v[s] <= v_prev and d[s] <= d_prev, where v_prev/d_prev come from stage s-1, or in_valid/in_data for s=0.
  - d[s] loads only when v_prev=1; otherwise d holds (no needless toggling).
  - If r[s]=0, the stage holds.
- en=0: no state change at all. in_ready=0 and out_valid=0, so no transfer occurs on either side. occ is held.
- flush=1 (en don't-care): next edge all v<=0, data held. in_ready=0 and out_valid=0 in the flush cycle, so a simultaneous input beat is neither accepted nor lost silently. Flush wins over every transfer.
- Transfer definition: valid&ready on the same edge. Ordering is strictly FIFO. No duplication, no drop except by flush or reset.
- Latency: NREG cycles from input acceptance to out_valid on an unstalled chain. Throughput is 1 beat/cycle at steady state.
- occ = popcount(v), derived from registers only (glitch-free after the edge). Maximum value is NREG.
- NREG=0 (pure wire mode):
  - out_data=in_data.
  - out_valid=in_valid&en&~flush.
  - in_ready=out_ready&en&~flush.
  - occ=0; no registers are inferred.

Test Plan:
- LEVELS=8, REG_INTERVAL=2 (NREG=4), out_ready=1, stream 0x01..0x10 back-to-back -> 0x01 on out 4 cycles after its acceptance, then one beat/cycle in order, occ steady at 4, in_ready never low.
- Same config, out_ready=0, offer 6 beats 0xA0..0xA5 -> exactly 4 accepted, in_ready=0 from the 5th offer, occ=4. Raise out_ready -> out 0xA0,0xA1,0xA2,0xA3, then 0xA4,0xA5 after the upstream re-offers them.
- Bubble collapse: load 0x11, hold upstream idle 2 cycles, load 0x22, out_ready=0 -> occ=2 with v[3],v[2] set. Release -> 0x11 then 0x22 on consecutive cycles.
- Flush with occ=3 and in_valid=1 (0x55) in the same cycle -> in_ready=0 that cycle, occ=0 next cycle, 0x55 and the 3 beats never appear. Stream restarts cleanly with latency 4.
- en=0 for 3 cycles mid-stream with out_ready=1 -> out_valid=0, in_ready=0, occ and data unchanged. Resumes with the same next beat, no loss or duplicate. Repeat with rst_n pulsed low mid-cycle -> immediate out_valid=0, occ=0, out_data=RESET_DATA.
- Parameter sweep:
  - REG_INTERVAL=0 -> combinational pass-through, 0-cycle latency, occ=0.
  - LEVELS=8, REG_INTERVAL=3 -> NREG=3 (levels 0,3,6), latency 3.
  - LEVELS=1, REG_INTERVAL=1 -> NREG=1, full-rate with out_ready=1.
